// File: rtl/ahb_mac_acc_pkg.sv
// rtl/ahb_mac_acc_pkg.sv - register map, bit positions and FSM encoding shared by the MAC accumulator
package ahb_mac_acc_pkg;

  localparam logic [7:0] OFF_A      = 8'h00;
  localparam logic [7:0] OFF_W      = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_ACC    = 8'h10;
  localparam logic [7:0] OFF_Q      = 8'h14;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLEAR    = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_SHIFT_LO = 4;
  localparam int CTRL_SHIFT_HI = 6;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_OVF  = 3;

  localparam int PROD_W = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic [7:0] lane_byte(input logic [31:0] v, input logic [1:0] idx);
    return v[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ahb_mac_acc_mac_lane.sv
// rtl/ahb_mac_acc_mac_lane.sv - one int8 x int8 product added into the accumulator with signed overflow flag
module mac_lane
  import ahb_mac_acc_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [7:0]       a_i,
  input  logic [7:0]       w_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;

  assign prod     = PROD_W'($signed(a_i)) * PROD_W'($signed(w_i));
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum_o    = acc_i + prod_ext;
  // Overflow only when both addends share a sign and the wrapped sum flips it.
  assign ovf_o    = (acc_i[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_o[ACC_W-1] != acc_i[ACC_W-1]);

endmodule

// File: rtl/ahb_mac_acc.sv
// rtl/ahb_mac_acc.sv - AHB-Lite 4-lane int8 dot-product accumulator with saturated Q; IRQ port under MAC_ACC_IRQ_EN
module ahb_mac_acc
  import ahb_mac_acc_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
`ifdef MAC_ACC_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  logic             vld_q, wr_q;
  logic [7:0]       addr_q;
  logic [31:0]      a_q, a_d, w_q, w_d, sa_q, sa_d, sw_q, sw_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]       shift_q, shift_d;
  logic             done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic [1:0]       lane_q, lane_d;
  state_e           state_q, state_d;
  logic             ie;

  logic wr_en, rd_en, ctrl_wr, stat_wr, start_wr, clear_wr;
  logic busy, take_start, err_set, step, finish;
  logic [ACC_W-1:0] lane_sum;
  logic             lane_ovf;
  logic             unused_bus;

  assign HREADYOUT  = 1'b1;
  assign HRESP      = 2'b00;
  assign unused_bus = ^{HSIZE, HTRANS[0], HADDR[31:8]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      vld_q  <= HSEL & HREADY & HTRANS[1];
      wr_q   <= HWRITE;
      addr_q <= HADDR[7:0];
    end
  end

  assign wr_en    = vld_q & wr_q;
  assign rd_en    = vld_q & ~wr_q;
  assign ctrl_wr  = wr_en && (addr_q == OFF_CTRL);
  assign stat_wr  = wr_en && (addr_q == OFF_STATUS);
  assign start_wr = ctrl_wr & HWDATA[CTRL_START];
  assign clear_wr = ctrl_wr & HWDATA[CTRL_CLEAR];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // CLEAR always lands in IDLE first, so a combined CLEAR+START restarts cleanly.
  always_comb begin
    state_d = state_q;
    if (clear_wr) begin
      state_d = start_wr ? S_RUN : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_wr) state_d = S_RUN;
        S_RUN:   if (lane_q == 2'd3) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == S_RUN);
    take_start = start_wr && (!busy || clear_wr);
    err_set    = start_wr && busy && !clear_wr;
    step       = busy && !clear_wr;
    finish     = step && (lane_q == 2'd3);
  end

  mac_lane #(.ACC_W(ACC_W)) u_lane (
    .a_i   (lane_byte(sa_q, lane_q)),
    .w_i   (lane_byte(sw_q, lane_q)),
    .acc_i (acc_q),
    .sum_o (lane_sum),
    .ovf_o (lane_ovf)
  );

  always_comb begin
    a_d     = a_q;
    w_d     = w_q;
    sa_d    = sa_q;
    sw_d    = sw_q;
    acc_d   = acc_q;
    shift_d = shift_q;
    done_d  = done_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    lane_d  = lane_q;
    if (wr_en && (addr_q == OFF_A)) a_d = HWDATA;
    if (wr_en && (addr_q == OFF_W)) w_d = HWDATA;
    if (ctrl_wr) shift_d = HWDATA[CTRL_SHIFT_HI:CTRL_SHIFT_LO];
    if (stat_wr) begin
      if (HWDATA[STAT_DONE]) done_d = 1'b0;
      if (HWDATA[STAT_ERR])  err_d  = 1'b0;
      if (HWDATA[STAT_OVF])  ovf_d  = 1'b0;
    end
    if (clear_wr) begin
      acc_d  = '0;
      done_d = 1'b0;
    end
    if (take_start) begin
      sa_d   = a_q;
      sw_d   = w_q;
      lane_d = 2'd0;
      done_d = 1'b0;
    end
    if (err_set) err_d = 1'b1;
    if (step) begin
      acc_d  = lane_sum;
      lane_d = lane_q + 2'd1;
      if (lane_ovf) ovf_d  = 1'b1;
      if (finish)   done_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_q     <= '0;
      w_q     <= '0;
      sa_q    <= '0;
      sw_q    <= '0;
      acc_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      lane_q  <= '0;
    end else begin
      a_q     <= a_d;
      w_q     <= w_d;
      sa_q    <= sa_d;
      sw_q    <= sw_d;
      acc_q   <= acc_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      lane_q  <= lane_d;
    end
  end

`ifdef MAC_ACC_IRQ_EN
  logic ie_q, irq_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) ie_q <= HWDATA[CTRL_IE];
      irq_q <= done_q & ie_q;
    end
  end
  assign ie  = ie_q;
  assign IRQ = irq_q;
`else
  assign ie = 1'b0;
`endif

  logic signed [ACC_W-1:0] acc_sh;
  logic [ACC_W-8:0]        q_hi;
  logic [7:0]              q;

  assign acc_sh = $signed(acc_q) >>> shift_q;
  assign q_hi   = acc_sh[ACC_W-1:7];

  // In range only when every bit above bit 7 repeats the sign.
  always_comb begin
    q = acc_sh[7:0];
    if (!((&q_hi) || !(|q_hi))) q = acc_sh[ACC_W-1] ? 8'h80 : 8'h7F;
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (addr_q)
        OFF_A:    HRDATA = a_q;
        OFF_W:    HRDATA = w_q;
        OFF_CTRL: begin
          HRDATA[CTRL_SHIFT_HI:CTRL_SHIFT_LO] = shift_q;
          HRDATA[CTRL_IE]                     = ie;
        end
        OFF_STATUS: begin
          HRDATA[STAT_BUSY] = busy;
          HRDATA[STAT_DONE] = done_q;
          HRDATA[STAT_ERR]  = err_q;
          HRDATA[STAT_OVF]  = ovf_q;
        end
        OFF_ACC:  HRDATA = 32'($signed(acc_q));
        OFF_Q:    HRDATA[7:0] = q;
        default:  HRDATA = '0;
      endcase
    end
  end

endmodule

// File: doc/ahb_mac_acc.md
AHB_MAC_ACC -- requirements
Module: ahb_mac_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 32, accumulator width in bits (legal 20..32).
REQ-002 SHALL have port HCLK input 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port HRESETn input 1, asynchronous active-low reset.
REQ-004 SHALL have AHB-Lite slave inputs: HSEL 1, HREADY 1, HTRANS 2, HSIZE 3 (ignored), HWRITE 1, HADDR 32, HWDATA 32.
REQ-005 SHALL have outputs HREADYOUT 1 (tied 1), HRESP 2 (tied OKAY), HRDATA 32 (read data).
REQ-006 SHALL have output IRQ 1 only when MAC_ACC_IRQ_EN is defined.

Function
REQ-007 SHALL be the upstream pre-activation stage: 4-lane int8 dot-product accumulator whose Q output is the signed 8-bit operand for the tanh LUT accelerator.
REQ-008 SHALL register an access (HSEL&HREADY&HTRANS[1]) with HADDR[7:0] in the address phase; it SHALL take HWDATA in the following cycle.
REQ-009 SHALL decode word offsets: 0x00 A (4 packed int8), 0x04 W (4 packed int8), 0x08 CTRL, 0x0C STATUS, 0x10 ACC (sign-extended to 32), 0x14 Q; other offsets read 0, writes ignored.
REQ-010 CTRL SHALL be: bit0 START (self-clearing, reads 0), bit1 CLEAR (self-clearing, reads 0), bit2 IE, bits6:4 SHIFT.
REQ-011 STATUS SHALL be: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 OVF; writing 1 clears DONE/ERR/OVF; BUSY is read-only.
REQ-012 FSM SHALL have states IDLE and RUN; START in IDLE snapshots A and W, clears DONE, zeroes the lane counter, and enters RUN the next cycle.
REQ-013 In RUN, each cycle SHALL add sext(A[8i+7:8i])*sext(W[8i+7:8i]) for lane i=0..3 to ACC; after lane 3 it SHALL return to IDLE and set DONE.
REQ-014 Latency: START data-phase at cycle N -> BUSY=1 at N+1 -> final ACC and DONE=1 visible at N+5.
REQ-015 ACC SHALL accumulate across operations until CLEAR; addition SHALL wrap modulo 2^ACC_W and set sticky OVF on signed overflow.
REQ-016 Q SHALL be combinational: signed ACC arithmetic-shifted right by SHIFT, saturated to [-128,127].
REQ-017 START while BUSY SHALL be ignored and SET ERR; the in-flight operation SHALL continue.
REQ-018 CLEAR SHALL zero ACC and DONE and abort RUN to IDLE; CLEAR with START in the same write SHALL act as CLEAR then START on the zeroed ACC.
REQ-019 Writes to A or W during RUN SHALL update the registers without affecting the snapshot in use.

Reset
REQ-020 HRESETn low SHALL force IDLE and zero A, W, ACC, SHIFT, IE, DONE, ERR, OVF, lane counter and the registered address/control; HRDATA then reads 0 and IRQ reads 0.
REQ-021 Reset mid-RUN SHALL abandon the operation with no partial DONE.

Configuration
REQ-022 With MAC_ACC_IRQ_EN defined, IRQ SHALL be registered DONE&IE; without it, no IRQ port exists and CTRL bit2 SHALL read 0 and ignore writes.

Structure
REQ-023 A shared package SHALL hold the register offsets, CTRL/STATUS bit positions and the FSM state encoding.
REQ-024 A sub-module mac_lane SHALL implement the signed 8x8 multiply, sign extension to ACC_W and overflow detection; the top SHALL hold the bus interface, registers and FSM.

Verification
REQ-025 A=0x04030201, W=0x01010101, START -> BUSY for 4 cycles, ACC=0x0000000A, Q=0x0A, DONE=1.
REQ-026 A=0x80808080, W=0x7F7F7F7F, SHIFT=4, START -> ACC=0xFFFF0200, Q=0x80 (saturated).
REQ-027 START, then START again 2 cycles later -> ERR=1, ACC equals the single-operation result; writing 0x4 to STATUS -> ERR=0.
REQ-028 ACC=10, write CTRL=0x3 -> ACC restarts from 0 and ends at the new dot product; CLEAR alone mid-RUN -> IDLE, ACC=0, DONE=0.
REQ-029 HRESETn pulsed at RUN lane 2 -> all registers 0, BUSY=0, DONE=0 after release.
REQ-030 With MAC_ACC_IRQ_EN and IE=1, completion -> IRQ=1 one cycle after DONE; writing 0x2 to STATUS -> IRQ=0.
